// File: rtl/vector_store_serializer.sv
// Serializes a masked six-lane result vector into single-lane memory writes, lowest lane first.
// Latency: first write the cycle after start, one cycle per lane at MemReady=1, then a one-cycle done.
// Backpressure: MemReady low holds the current write stable; start is ignored while busy.
module vector_store_serializer #(
    parameter int N      = 8,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [5:0][N-1:0]     ALUResult,
    input  logic [5:0]            LaneMask,
    input  logic [ADDR_W-1:0]     BaseAddr,
    input  logic                  MemReady,
    output logic                  busy,
    output logic                  MemWrite,
    output logic [ADDR_W-1:0]     MemAddr,
    output logic [N-1:0]          MemWData,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                state_q;
    logic [5:0]            mask_q;
    logic [5:0][N-1:0]     data_q;
    logic [ADDR_W-1:0]     base_q;
    logic                  busy_q;
    logic                  we_q;
    logic                  done_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [N-1:0]          wdata_q;

    logic [2:0]            cur_idx;
    logic [2:0]            nxt_idx;
    logic [2:0]            start_idx;
    logic [5:0]            mask_d;

    function automatic logic [2:0] lowest_lane(input logic [5:0] m);
        lowest_lane = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (m[i]) lowest_lane = 3'(i);
        end
    endfunction

    // The lane on the bus is always the lowest bit still in the remaining mask.
    always_comb begin
        cur_idx   = lowest_lane(mask_q);
        mask_d    = mask_q & ~(6'b000001 << cur_idx);
        nxt_idx   = lowest_lane(mask_d);
        start_idx = lowest_lane(LaneMask);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            data_q  <= '0;
            base_q  <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q <= ALUResult;
                        base_q <= BaseAddr;
                        mask_q <= LaneMask;
                        busy_q <= 1'b1;
                        if (LaneMask != '0) begin
                            state_q <= WRITE;
                            we_q    <= 1'b1;
                            addr_q  <= BaseAddr + ADDR_W'(start_idx);
                            wdata_q <= ALUResult[start_idx];
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (MemReady) begin
                        mask_q <= mask_d;
                        if (mask_d == '0) begin
                            state_q <= DONE;
                            we_q    <= 1'b0;
                            addr_q  <= '0;
                            wdata_q <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q  <= base_q + ADDR_W'(nxt_idx);
                            wdata_q <= data_q[nxt_idx];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign MemWrite = we_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign done     = done_q;

endmodule

// File: doc/vector_store_serializer.md
VECTOR_STORE_SERIALIZER -- requirements
Module: vector_store_serializer

Interface
REQ-001 SHALL have parameter N, default 8, lane data width (matches execute-stage lane width).
REQ-002 SHALL have parameter ADDR_W, default 16, data-memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
REQ-005 SHALL have port start  input  1  one-cycle request to store the presented lane vector.
REQ-006 SHALL have port ALUResult  input  [5:0][N-1:0]  six-lane result vector from the execute stage.
REQ-007 SHALL have port LaneMask  input  6  bit i set = lane i to be stored.
REQ-008 SHALL have port BaseAddr  input  ADDR_W  address of lane 0.
REQ-009 SHALL have port MemReady  input  1  memory accepts the current write when high.
REQ-010 SHALL have port busy  output  1  pipeline stall; high whenever the block is not IDLE.
REQ-011 SHALL have port MemWrite  output  1  write strobe to data memory.
REQ-012 SHALL have port MemAddr  output  ADDR_W  write address.
REQ-013 SHALL have port MemWData  output  N  write data.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the store completes.

Function
REQ-015 SHALL implement an FSM with states IDLE, WRITE, DONE.
REQ-016 In IDLE with start==1, SHALL register ALUResult, LaneMask and BaseAddr into internal copies on that edge; later changes on these inputs SHALL NOT affect the operation.
REQ-017 From IDLE on start: SHALL go to WRITE if captured mask !=0, otherwise go directly to DONE.
REQ-018 start SHALL be ignored in WRITE and DONE; no queuing.
REQ-019 In WRITE, current lane SHALL be the lowest-index set bit of the remaining mask; masked-off lanes SHALL consume no cycles.
REQ-020 In WRITE: MemWrite=1, MemWData=captured lane data, MemAddr=captured BaseAddr + lane index, computed modulo 2^ADDR_W (wraps, no carry out).
REQ-021 A write SHALL complete only on an edge where MemWrite==1 and MemReady==1; on completion the lane's bit SHALL be cleared from the remaining mask.
REQ-022 While MemReady==0, MemWrite, MemAddr and MemWData SHALL hold stable.
REQ-023 When the last remaining bit completes, SHALL go to DONE on that edge; no idle cycle between consecutive lane writes.
REQ-024 In DONE: done=1 for exactly one cycle, MemWrite=0; next state IDLE unconditionally.
REQ-025 When MemWrite==0, MemAddr and MemWData SHALL be driven to 0.
REQ-026 busy SHALL be 1 in WRITE and DONE, 0 in IDLE.
REQ-027 Latency: with start at edge t, MemReady held 1 and k set lanes (k>=1), first MemWrite SHALL be in cycle t+1, done in cycle t+1+k; k=0 gives done in cycle t+1.

Reset
REQ-028 On reset==0 at any edge, including mid-WRITE, SHALL enter IDLE and clear remaining mask and captured data; in-flight lanes are discarded.
REQ-029 Reset values: busy=0, MemWrite=0, MemAddr=0, MemWData=0, done=0.
REQ-030 reset SHALL take priority over start on the same edge.

Verification
REQ-031 Full mask: N=8, BaseAddr=0x0100, LaneMask=6'b111111, lanes 0..5 = 0x10..0x15, MemReady=1 -> six consecutive writes (0x0100,0x10)..(0x0105,0x15), done one cycle later, busy high 7 cycles.
REQ-032 Sparse mask: LaneMask=6'b100101 -> exactly three writes to BaseAddr+0, +2, +5 in consecutive cycles, then done.
REQ-033 Backpressure: MemReady=0 for 3 cycles during lane 1 -> lane 1 addr/data held stable 4 cycles, lane 1 written exactly once, total cycles extended by 3.
REQ-034 Wrap and empty: BaseAddr=0xFFFE, mask=6'b001100 -> writes to 0x0000 and 0x0001; separate start with mask=0 -> no MemWrite, done in cycle t+1.
REQ-035 Reset mid-op: reset=0 during 3rd lane write -> next cycle busy=0, MemWrite=0, done never pulses; start issued while busy (before reset) ignored.
